// File: rtl/wb_host_if.sv
// Bundle of the command, response and Wishbone initiator signals around wb_host.
// The master modport is the wb_host view; slave is the command source plus bus responder.
`ifndef WB_WIDTH
`define WB_WIDTH 32
`endif

interface wb_host_if;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [`WB_WIDTH-1:0] cmd_adr;
    logic [`WB_WIDTH-1:0] cmd_dat;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [`WB_WIDTH-1:0] rsp_dat;
    logic                 rsp_err;

    logic                 wbm_cyc_o;
    logic                 wbm_stb_o;
    logic                 wbm_we_o;
    logic [`WB_WIDTH-1:0] wbm_adr_o;
    logic [`WB_WIDTH-1:0] wbm_dat_o;
    logic                 wbm_ack_i;
    logic [`WB_WIDTH-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wb_host.sv
// Wishbone classic initiator: one valid/ready command becomes one bus transaction,
// bounded by a TIMEOUT-cycle ACK wait, and yields exactly one response.
`ifndef WB_WIDTH
`define WB_WIDTH 32
`endif

module wb_host #(
    parameter int TIMEOUT = 15
) (
    input  logic   wb_clk_i,
    input  logic   wb_rstn_i,
    wb_host_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t               state_q;
    state_t               state_next;

    logic                 ready_q;
    logic                 cyc_q;
    logic                 we_q;
    logic [`WB_WIDTH-1:0] adr_q;
    logic [`WB_WIDTH-1:0] dat_q;
    logic [7:0]           cnt_q;

    logic                 rsp_valid_q;
    logic [`WB_WIDTH-1:0] rsp_dat_q;
    logic                 rsp_err_q;

    logic                 accept;
    logic                 ack_hit;
    logic                 expire;
    logic                 consume;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // ACK is checked before the counter so an ACK in the last allowed cycle still succeeds.
    always_comb begin
        state_next = state_q;
        accept     = 1'b0;
        ack_hit    = 1'b0;
        expire     = 1'b0;
        consume    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready_q && bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (bus.wbm_ack_i) begin
                    ack_hit    = 1'b1;
                    state_next = RESP;
                end else if (cnt_q == LAST_CNT) begin
                    expire     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    consume    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus lines are cleared on leaving BUS so an idle bus reads as all zeros.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ready_q <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            ready_q <= (state_next == IDLE);
            if (accept) begin
                cyc_q <= 1'b1;
                we_q  <= bus.cmd_we;
                adr_q <= bus.cmd_adr;
                dat_q <= bus.cmd_dat;
                cnt_q <= '0;
            end else if (ack_hit || expire) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
                adr_q <= '0;
                dat_q <= '0;
            end else if (state_q == BUS) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (ack_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_dat_q   <= we_q ? '0 : bus.wbm_dat_i;
                rsp_err_q   <= 1'b0;
            end else if (expire) begin
                rsp_valid_q <= 1'b1;
                rsp_dat_q   <= '0;
                rsp_err_q   <= 1'b1;
            end else if (consume) begin
                rsp_valid_q <= 1'b0;
                rsp_dat_q   <= '0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_host.sv
// Bench for wb_host: directed scenarios plus random commands against a responder with
// programmable ACK delay; expected responses come from a transaction-level model.
`ifndef WB_WIDTH
`define WB_WIDTH 32
`endif

module tb_wb_host;

    localparam int W       = `WB_WIDTH;
    localparam int TIMEOUT = 15;

    logic wb_clk_i;
    logic wb_rstn_i;

    wb_host_if ifc ();

    wb_host #(.TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rstn_i (wb_rstn_i),
        .bus       (ifc.master)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Responder: one data word per address region (programmer, pads, debug, entropy).
    logic [W-1:0] region_data [4];
    bit           ack_en;
    int           ack_delay;
    int           bus_cnt;
    int           prog_wr_count;

    assign ifc.wbm_ack_i = ack_en && ifc.wbm_cyc_o && ifc.wbm_stb_o && (bus_cnt == ack_delay);
    assign ifc.wbm_dat_i = region_data[ifc.wbm_adr_o[W-1 -: 2]];

    always @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            bus_cnt <= 0;
        end else begin
            bus_cnt <= (ifc.wbm_cyc_o && ifc.wbm_stb_o) ? bus_cnt + 1 : 0;
            if (ifc.wbm_cyc_o && ifc.wbm_stb_o && ifc.wbm_we_o && ifc.wbm_ack_i
                && ifc.wbm_adr_o[W-1 -: 2] == 2'b00)
                prog_wr_count <= prog_wr_count + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, "_cyc"}, W'(ifc.wbm_cyc_o), '0);
        check({tag, "_stb"}, W'(ifc.wbm_stb_o), '0);
        check({tag, "_we"},  W'(ifc.wbm_we_o),  '0);
        check({tag, "_adr"}, ifc.wbm_adr_o, '0);
        check({tag, "_dat"}, ifc.wbm_dat_o, '0);
    endtask

    // One full command/response exchange, checked against the transaction model.
    task automatic run_cmd(input logic we, input logic [W-1:0] adr, input logic [W-1:0] dat,
                           input int delay, input bit ack_on, input string tag);
        bit           exp_err;
        int           exp_stb;
        logic [W-1:0] exp_dat;
        int           stb_cnt;
        exp_err = !ack_on || (delay >= TIMEOUT);
        exp_stb = exp_err ? TIMEOUT : delay + 1;
        exp_dat = (exp_err || we) ? '0 : region_data[adr[W-1 -: 2]];
        ack_en    = ack_on;
        ack_delay = delay;

        check({tag, "_ready"}, W'(ifc.cmd_ready), W'(1));
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = we;
        ifc.cmd_adr   = adr;
        ifc.cmd_dat   = dat;
        tick();
        ifc.cmd_valid = 1'b0;
        ifc.cmd_dat   = W'($urandom);
        check({tag, "_cyc"}, W'(ifc.wbm_cyc_o), W'(1));
        check({tag, "_we"},  W'(ifc.wbm_we_o),  W'(we));
        check({tag, "_adr"}, ifc.wbm_adr_o, adr);
        check({tag, "_wdat"}, ifc.wbm_dat_o, dat);

        stb_cnt = 0;
        for (int i = 0; i < TIMEOUT + 8 && !ifc.rsp_valid; i++) begin
            if (ifc.wbm_stb_o) stb_cnt++;
            tick();
        end
        check({tag, "_rsp_valid"}, W'(ifc.rsp_valid), W'(1));
        check({tag, "_stb_cycles"}, W'(stb_cnt), W'(exp_stb));
        check({tag, "_rsp_err"}, W'(ifc.rsp_err), W'(exp_err));
        check({tag, "_rsp_dat"}, ifc.rsp_dat, exp_dat);
        check({tag, "_cyc_low"}, W'(ifc.wbm_cyc_o), '0);

        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        check({tag, "_consumed"}, W'(ifc.rsp_valid), '0);
        check({tag, "_ready_again"}, W'(ifc.cmd_ready), W'(1));
        check({tag, "_gap"}, W'(ifc.wbm_cyc_o), '0);
    endtask

    initial begin
        logic [W-1:0] adr2;
        logic [W-1:0] dat2;
        logic [W-1:0] held_dat;
        logic [W-1:0] exp_rd;
        int           wr_before;
        bit           saw_rsp;
        bit           saw_cyc;

        wb_rstn_i     = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = '0;
        ifc.cmd_dat   = '0;
        ifc.rsp_ready = 1'b0;
        ack_en        = 1'b1;
        ack_delay     = 0;
        prog_wr_count = 0;
        for (int i = 0; i < 4; i++) region_data[i] = W'($urandom);

        // Reset and idle
        tick();
        tick();
        check("rst_cmd_ready", W'(ifc.cmd_ready), '0);
        check("rst_rsp_valid", W'(ifc.rsp_valid), '0);
        check("rst_rsp_dat", ifc.rsp_dat, '0);
        check("rst_rsp_err", W'(ifc.rsp_err), '0);
        check_bus_idle("rst");
        wb_rstn_i = 1'b1;
        tick();
        check("post_rst_ready", W'(ifc.cmd_ready), W'(1));
        check_bus_idle("post_rst");

        // Programmer write with a same-cycle ACK
        wr_before = prog_wr_count;
        run_cmd(1'b1, W'(32'h0000_0012), W'(32'h0000_ABCD), 0, 1'b1, "write");
        check("prog_strobe_once", W'(prog_wr_count - wr_before), W'(1));

        // Debug read
        region_data[2] = W'(32'h1234_5678);
        run_cmd(1'b0, W'(32'h8000_0003), '0, 0, 1'b1, "dbg_read");

        // No ACK: abort after TIMEOUT strobe cycles
        run_cmd(1'b0, W'(32'h4000_0020), '0, 0, 1'b0, "timeout");

        // ACK in the final allowed cycle wins; one cycle later is a timeout
        run_cmd(1'b0, W'(32'hC000_0004), '0, TIMEOUT - 1, 1'b1, "ack_last");
        run_cmd(1'b0, W'(32'hC000_0008), '0, TIMEOUT, 1'b1, "ack_late");

        // Back-pressure: response held while a second command waits
        ack_en    = 1'b1;
        ack_delay = 0;
        region_data[1] = W'($urandom);
        exp_rd = region_data[1];
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = {2'b01, (W-2)'($urandom)};
        tick();
        ifc.cmd_valid = 1'b0;
        tick();
        check("bp_latency", W'(ifc.rsp_valid), W'(1));
        check("bp_rd_dat", ifc.rsp_dat, exp_rd);
        check("bp_rd_err", W'(ifc.rsp_err), '0);
        held_dat = ifc.rsp_dat;
        adr2 = {2'b00, (W-2)'($urandom)};
        dat2 = W'($urandom);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = 1'b1;
        ifc.cmd_adr   = adr2;
        ifc.cmd_dat   = dat2;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", W'(ifc.rsp_valid), W'(1));
            check("bp_hold_dat", ifc.rsp_dat, held_dat);
            check("bp_hold_err", W'(ifc.rsp_err), '0);
            check("bp_hold_ready", W'(ifc.cmd_ready), '0);
            check("bp_hold_cyc", W'(ifc.wbm_cyc_o), '0);
        end
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        check("bp_release_valid", W'(ifc.rsp_valid), '0);
        check("bp_release_ready", W'(ifc.cmd_ready), W'(1));
        check("bp_release_cyc", W'(ifc.wbm_cyc_o), '0);
        tick();
        ifc.cmd_valid = 1'b0;
        check("bp_second_cyc", W'(ifc.wbm_cyc_o), W'(1));
        check("bp_second_adr", ifc.wbm_adr_o, adr2);
        check("bp_second_dat", ifc.wbm_dat_o, dat2);
        tick();
        check("bp_second_rsp", W'(ifc.rsp_valid), W'(1));
        check("bp_second_err", W'(ifc.rsp_err), '0);
        check("bp_second_rdat", ifc.rsp_dat, '0);
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;

        // Random commands against the transaction model
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) region_data[i] = W'($urandom);
            run_cmd(1'($urandom), W'($urandom), W'($urandom),
                    int'($urandom_range(0, TIMEOUT + 2)), ($urandom_range(0, 7) != 0), "rand");
        end

        // Reset in the middle of a slow transaction
        ack_en    = 1'b1;
        ack_delay = 8;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = W'(32'h8000_0010);
        tick();
        ifc.cmd_valid = 1'b0;
        tick();
        check("mid_stb_high", W'(ifc.wbm_stb_o), W'(1));
        #2;
        wb_rstn_i = 1'b0;
        #1;
        check("mid_async_cyc", W'(ifc.wbm_cyc_o), '0);
        check("mid_async_stb", W'(ifc.wbm_stb_o), '0);
        tick();
        wb_rstn_i = 1'b1;
        ifc.rsp_ready = 1'b1;
        saw_rsp = 1'b0;
        saw_cyc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.rsp_valid) saw_rsp = 1'b1;
            if (ifc.wbm_cyc_o) saw_cyc = 1'b1;
        end
        ifc.rsp_ready = 1'b0;
        check("mid_no_rsp", W'(saw_rsp), '0);
        check("mid_no_cyc", W'(saw_cyc), '0);
        check("mid_ready", W'(ifc.cmd_ready), W'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
